if_fetch_req_ctrl: RTL and testbench

Fetch-request controller between the fetch-address stage and the instruction-cache SRAM-like bus. It registers fetch requests, drives `inst_req`/`inst_addr`, and tracks up to `MAX_OUTST` in-flight transactions in an in-order tag FIFO. It marks in-flight entries canceled on branch-mispredict or exception flush, and silently discards their returning data. It is the sequencer for the second fetch stage: its `resp_valid_o` qualifies the `inst_data_ok` data that the downstream cache-trace stage consumes.

---
 rtl/if_fetch_req_ctrl.sv | 131 +++++++++++++
 tb/tb_if_fetch_req_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_req_ctrl.sv
// Fetch-request controller: issues inst-cache bus requests, tracks in-flight tags in order, drops flushed responses.
// Optional IF_FETCH_PERF_EN adds a saturating stall counter output.
module if_fetch_req_ctrl #(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_valid_i,
  input  logic [31:0]      pc_vaddr_i,
  input  logic [31:0]      pc_paddr_i,
  input  logic             pc_hasException_i,
  output logic             pc_ready_o,
  output logic             inst_req_o,
  output logic [31:0]      inst_addr_o,
  input  logic             inst_addr_ok_i,
  input  logic             inst_data_ok_i,
  input  logic             BSC_needCancel_w_i,
  input  logic             CP0_excOccur_w_i,
  output logic             resp_valid_o,
  output logic [31:0]      resp_vaddr_o,
  output logic             resp_hasException_o,
  output logic [CNT_W-1:0] outst_cnt_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt_o
`endif
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [1:0] {IDLE, REQ, EXC} state_t;

  state_t                 state;
  logic [31:0]            req_vaddr;
  logic                   req_cancel;
  logic [31:0]            fifo_vaddr [MAX_OUTST];
  logic [MAX_OUTST-1:0]   fifo_cancel;
  logic [PTR_W-1:0]       wptr;
  logic [PTR_W-1:0]       rptr;

  logic flush;
  logic slot_ok;
  logic base_ok;
  logic exc_ok;
  logic accept;
  logic push;
  logic pop;
  logic push_cancel;
  logic exc_resp;

  assign flush = BSC_needCancel_w_i || CP0_excOccur_w_i;

  // The held request still needs a slot once the bus takes it.
  assign slot_ok = ({1'b0, outst_cnt_o} + {{CNT_W{1'b0}}, (state == REQ)})
                   < (CNT_W + 1)'(MAX_OUTST);
  assign base_ok = !flush && (state == IDLE || (state == REQ && inst_addr_ok_i)) && slot_ok;
  assign exc_ok  = (state == IDLE) && (outst_cnt_o == '0);
  assign pc_ready_o = base_ok && (!pc_hasException_i || exc_ok);

  assign accept      = pc_valid_i && pc_ready_o;
  assign push        = (state == REQ) && inst_addr_ok_i;
  assign pop         = inst_data_ok_i && (outst_cnt_o != '0);
  assign push_cancel = flush || req_cancel;
  assign exc_resp    = (state == EXC);

  assign resp_valid_o        = !flush && (exc_resp || (pop && !fifo_cancel[rptr]));
  assign resp_hasException_o = !flush && exc_resp;
  assign resp_vaddr_o        = exc_resp ? req_vaddr : (pop ? fifo_vaddr[rptr] : 32'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      inst_req_o  <= 1'b0;
      inst_addr_o <= 32'h0;
      req_vaddr   <= 32'h0;
      req_cancel  <= 1'b0;
    end else if (accept) begin
      req_vaddr  <= pc_vaddr_i;
      req_cancel <= 1'b0;
      if (pc_hasException_i) begin
        state      <= EXC;
        inst_req_o <= 1'b0;
      end else begin
        state       <= REQ;
        inst_req_o  <= 1'b1;
        inst_addr_o <= pc_paddr_i;
      end
    end else if (state == EXC || push) begin
      state      <= IDLE;
      inst_req_o <= 1'b0;
      req_cancel <= 1'b0;
    end else if (flush) begin
      // A held request cannot be withdrawn; remember to cancel it on push.
      req_cancel <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      fifo_cancel <= '0;
      outst_cnt_o <= '0;
    end else begin
      if (flush) fifo_cancel <= '1;
      if (push) begin
        fifo_cancel[wptr] <= push_cancel;
        wptr              <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      if (push && !pop)      outst_cnt_o <= outst_cnt_o + CNT_W'(1);
      else if (pop && !push) outst_cnt_o <= outst_cnt_o - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_vaddr[wptr] <= req_vaddr;
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_o <= 32'h0;
    end else if (pc_valid_i && !pc_ready_o && !flush && perf_stall_cnt_o != 32'hFFFF_FFFF) begin
      perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_req_ctrl.sv
// Scenario bench for if_fetch_req_ctrl with an in-order response scoreboard.
module tb_if_fetch_req_ctrl;

  localparam int MAX_OUTST = 2;
  localparam int CNT_W     = $clog2(MAX_OUTST + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             pc_valid;
  logic [31:0]      pc_vaddr;
  logic [31:0]      pc_paddr;
  logic             pc_exc;
  logic             pc_ready;
  logic             inst_req;
  logic [31:0]      inst_addr;
  logic             addr_ok;
  logic             data_ok;
  logic             bsc_cancel;
  logic             cp0_exc;
  logic             resp_valid;
  logic [31:0]      resp_vaddr;
  logic             resp_exc;
  logic [CNT_W-1:0] outst_cnt;
`ifdef IF_FETCH_PERF_EN
  logic [31:0]      perf_stall_cnt;
`endif

  typedef struct packed {
    logic [31:0] vaddr;
    logic        canceled;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  if_fetch_req_ctrl #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc_valid_i          (pc_valid),
    .pc_vaddr_i          (pc_vaddr),
    .pc_paddr_i          (pc_paddr),
    .pc_hasException_i   (pc_exc),
    .pc_ready_o          (pc_ready),
    .inst_req_o          (inst_req),
    .inst_addr_o         (inst_addr),
    .inst_addr_ok_i      (addr_ok),
    .inst_data_ok_i      (data_ok),
    .BSC_needCancel_w_i  (bsc_cancel),
    .CP0_excOccur_w_i    (cp0_exc),
    .resp_valid_o        (resp_valid),
    .resp_vaddr_o        (resp_vaddr),
    .resp_hasException_o (resp_exc),
    .outst_cnt_o         (outst_cnt)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_stall_cnt_o    (perf_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    pc_valid = 0; pc_vaddr = 0; pc_paddr = 0; pc_exc = 0;
    addr_ok = 0; data_ok = 0; bsc_cancel = 0; cp0_exc = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL reset_inst_req got %b exp 0", inst_req); end
    checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL reset_inst_addr got %h exp 0", inst_addr); end
    checks++; if (outst_cnt !== '0) begin failures++; $display("FAIL reset_cnt got %0d exp 0", outst_cnt); end
    checks++; if (resp_valid !== 1'b0 || resp_exc !== 1'b0 || resp_vaddr !== 32'h0) begin
      failures++; $display("FAIL reset_resp got v=%b x=%b a=%h exp 0/0/0", resp_valid, resp_exc, resp_vaddr);
    end
    checks++; if (pc_ready !== 1'b1) begin failures++; $display("FAIL reset_pc_ready got %b exp 1", pc_ready); end
    tick();
  endtask

  task automatic test_single();
    pc_valid = 1; pc_vaddr = 32'hBFC0_0000; pc_paddr = 32'h1FC0_0000;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b1) begin failures++; $display("FAIL single_accept got %b exp 1", pc_ready); end
    sb.push_back('{32'hBFC0_0000, 1'b0, 1'b0});
    tick();
    pc_valid = 0; addr_ok = 1;
    @(negedge clk);
    checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL single_req got %b exp 1", inst_req); end
    checks++; if (inst_addr !== 32'h1FC0_0000) begin failures++; $display("FAIL single_addr got %h exp 1fc00000", inst_addr); end
    tick();
    addr_ok = 0;
    @(negedge clk);
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL single_req_drop got %b exp 0", inst_req); end
    checks++; if (outst_cnt !== 1) begin failures++; $display("FAIL single_cnt3 got %0d exp 1", outst_cnt); end
    tick();
    data_ok = 1;
    @(negedge clk);
    checks++; if (outst_cnt !== 1) begin failures++; $display("FAIL single_cnt4 got %0d exp 1", outst_cnt); end
    e = sb.pop_front();
    checks++; if (resp_valid !== !e.canceled) begin failures++; $display("FAIL single_resp_valid got %b exp %b", resp_valid, !e.canceled); end
    checks++; if (resp_vaddr !== e.vaddr) begin failures++; $display("FAIL single_resp_vaddr got %h exp %h", resp_vaddr, e.vaddr); end
    tick();
    data_ok = 0;
    @(negedge clk);
    checks++; if (outst_cnt !== 0) begin failures++; $display("FAIL single_cnt5 got %0d exp 0", outst_cnt); end
    tick();
  endtask

  task automatic test_full();
    logic [31:0] va;
    logic [3:0]  pat;
    va  = 32'h8000_0000;
    pat = 4'b0011;
    addr_ok = 1; pc_valid = 1;
    for (int i = 0; i < 4; i++) begin
      pc_vaddr = va; pc_paddr = va & 32'h1FFF_FFFF;
      @(negedge clk);
      checks++; if (pc_ready !== pat[i]) begin failures++; $display("FAIL full_ready%0d got %b exp %b", i, pc_ready, pat[i]); end
      if (pat[i]) begin sb.push_back('{va, 1'b0, 1'b0}); va = va + 32'd4; end
      tick();
    end
    pc_vaddr = va; pc_paddr = va & 32'h1FFF_FFFF;
    data_ok = 1;
    @(negedge clk);
    checks++; if (outst_cnt !== 2) begin failures++; $display("FAIL full_cnt got %0d exp 2", outst_cnt); end
    checks++; if (pc_ready !== 1'b0) begin failures++; $display("FAIL full_ready_pop got %b exp 0", pc_ready); end
    e = sb.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_vaddr !== e.vaddr) begin
      failures++; $display("FAIL full_resp0 got v=%b a=%h exp v=1 a=%h", resp_valid, resp_vaddr, e.vaddr);
    end
    tick();
    data_ok = 0;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after got %b exp 1", pc_ready); end
    sb.push_back('{va, 1'b0, 1'b0});
    tick();
    pc_valid = 0;
    @(negedge clk);
    checks++; if (inst_req !== 1'b1 || inst_addr !== (va & 32'h1FFF_FFFF)) begin
      failures++; $display("FAIL full_reissue got r=%b a=%h exp r=1 a=%h", inst_req, inst_addr, va & 32'h1FFF_FFFF);
    end
    tick();
    addr_ok = 0;
    for (int i = 0; i < 2; i++) begin
      data_ok = 1;
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (resp_valid !== 1'b1 || resp_vaddr !== e.vaddr) begin
        failures++; $display("FAIL full_drain%0d got v=%b a=%h exp v=1 a=%h", i, resp_valid, resp_vaddr, e.vaddr);
      end
      tick();
    end
    data_ok = 0;
    @(negedge clk);
    checks++; if (outst_cnt !== 0) begin failures++; $display("FAIL full_cnt_end got %0d exp 0", outst_cnt); end
    tick();
  endtask

  task automatic test_flush();
    addr_ok = 1;
    for (int i = 0; i < 2; i++) begin
      pc_valid = 1; pc_vaddr = 32'hBFC0_0040 + 32'(i * 4); pc_paddr = pc_vaddr & 32'h1FFF_FFFF;
      @(negedge clk);
      checks++; if (pc_ready !== 1'b1) begin failures++; $display("FAIL flush_accept%0d got %b exp 1", i, pc_ready); end
      sb.push_back('{pc_vaddr, 1'b0, 1'b0});
      tick();
    end
    pc_valid = 0;
    tick();
    addr_ok = 0; bsc_cancel = 1;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got %b exp 0", pc_ready); end
    foreach (sb[i]) sb[i].canceled = 1'b1;
    tick();
    bsc_cancel = 0;
    for (int i = 0; i < 2; i++) begin
      data_ok = 1;
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (resp_valid !== !e.canceled) begin failures++; $display("FAIL flush_resp%0d got %b exp %b", i, resp_valid, !e.canceled); end
      tick();
    end
    data_ok = 0;
    pc_valid = 1; pc_vaddr = 32'hBFC0_0100; pc_paddr = 32'h1FC0_0100;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b1) begin failures++; $display("FAIL flush_next_accept got %b exp 1", pc_ready); end
    sb.push_back('{32'hBFC0_0100, 1'b0, 1'b0});
    tick();
    pc_valid = 0; addr_ok = 1;
    tick();
    addr_ok = 0;
    tick();
    data_ok = 1;
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_vaddr !== e.vaddr) begin
      failures++; $display("FAIL flush_next_resp got v=%b a=%h exp v=1 a=%h", resp_valid, resp_vaddr, e.vaddr);
    end
    tick();
    data_ok = 0;
  endtask

  task automatic test_flush_held();
    pc_valid = 1; pc_vaddr = 32'hBFC0_0200; pc_paddr = 32'h1FC0_0200;
    @(negedge clk);
    sb.push_back('{32'hBFC0_0200, 1'b0, 1'b0});
    tick();
    pc_valid = 0; cp0_exc = 1;
    @(negedge clk);
    foreach (sb[i]) sb[i].canceled = 1'b1;
    checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL held_req_flush got %b exp 1", inst_req); end
    tick();
    cp0_exc = 0;
    @(negedge clk);
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h1FC0_0200) begin
      failures++; $display("FAIL held_req_kept got r=%b a=%h exp r=1 a=1fc00200", inst_req, inst_addr);
    end
    tick();
    addr_ok = 1;
    tick();
    addr_ok = 0;
    @(negedge clk);
    checks++; if (inst_req !== 1'b0 || outst_cnt !== 1) begin
      failures++; $display("FAIL held_pushed got r=%b cnt=%0d exp r=0 cnt=1", inst_req, outst_cnt);
    end
    tick();
    data_ok = 1;
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (resp_valid !== !e.canceled) begin failures++; $display("FAIL held_resp got %b exp %b", resp_valid, !e.canceled); end
    tick();
    data_ok = 0;
    @(negedge clk);
    checks++; if (outst_cnt !== 0) begin failures++; $display("FAIL held_cnt got %0d exp 0", outst_cnt); end
    tick();
  endtask

  task automatic test_exception();
    pc_valid = 1; pc_vaddr = 32'hBFC0_0300; pc_paddr = 32'h1FC0_0300; addr_ok = 1;
    @(negedge clk);
    sb.push_back('{32'hBFC0_0300, 1'b0, 1'b0});
    tick();
    pc_vaddr = 32'hBFC0_0304; pc_paddr = 32'h1FC0_0304; pc_exc = 1;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b0) begin failures++; $display("FAIL exc_block_req got %b exp 0", pc_ready); end
    tick();
    addr_ok = 0;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b0) begin failures++; $display("FAIL exc_block_cnt got %b exp 0", pc_ready); end
    tick();
    data_ok = 1;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b0) begin failures++; $display("FAIL exc_block_pop got %b exp 0", pc_ready); end
    e = sb.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_vaddr !== e.vaddr || resp_exc !== 1'b0) begin
      failures++; $display("FAIL exc_drain got v=%b a=%h x=%b exp v=1 a=%h x=0", resp_valid, resp_vaddr, resp_exc, e.vaddr);
    end
    tick();
    data_ok = 0;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b1) begin failures++; $display("FAIL exc_accept got %b exp 1", pc_ready); end
    sb.push_back('{32'hBFC0_0304, 1'b0, 1'b1});
    tick();
    pc_valid = 0; pc_exc = 0;
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_exc !== e.exc || resp_vaddr !== e.vaddr || inst_req !== 1'b0) begin
      failures++; $display("FAIL exc_resp got v=%b x=%b a=%h r=%b exp v=1 x=%b a=%h r=0",
                           resp_valid, resp_exc, resp_vaddr, inst_req, e.exc, e.vaddr);
    end
    tick();
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || pc_ready !== 1'b1) begin
      failures++; $display("FAIL exc_idle got v=%b rdy=%b exp v=0 rdy=1", resp_valid, pc_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    addr_ok = 1; pc_valid = 1;
    for (int i = 0; i < 2; i++) begin
      pc_vaddr = 32'hBFC0_0400 + 32'(i * 4); pc_paddr = pc_vaddr & 32'h1FFF_FFFF;
      tick();
    end
    pc_valid = 0;
    tick();
    addr_ok = 0;
    @(negedge clk);
    checks++; if (outst_cnt !== 2) begin failures++; $display("FAIL rmid_cnt_pre got %0d exp 2", outst_cnt); end
    rst = 1;
    tick();
    rst = 0;
    sb.delete();
    @(negedge clk);
    checks++; if (outst_cnt !== 0 || inst_req !== 1'b0 || inst_addr !== 32'h0 || resp_valid !== 1'b0 || pc_ready !== 1'b1) begin
      failures++; $display("FAIL rmid_reset got cnt=%0d r=%b a=%h v=%b rdy=%b exp 0/0/0/0/1",
                           outst_cnt, inst_req, inst_addr, resp_valid, pc_ready);
    end
    tick();
    data_ok = 1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || resp_vaddr !== 32'h0) begin
      failures++; $display("FAIL rmid_late_data got v=%b a=%h exp v=0 a=0", resp_valid, resp_vaddr);
    end
    tick();
    data_ok = 0;
    @(negedge clk);
    checks++; if (outst_cnt !== 0) begin failures++; $display("FAIL rmid_cnt_post got %0d exp 0", outst_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_flush();
    test_flush_held();
    test_exception();
    test_reset_mid();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
